// File: rtl/argmax_scan_unit_if.sv
// Score-vector handshake and result bundle between the classifier tail and the argmax scanner.
interface argmax_scan_unit_if #(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16
);
  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data;
  logic                             i_valid;
  logic                             o_ready;
  logic [31:0]                      o_data;
  logic [INPUT_WIDTH-1:0]           o_value;
  logic                             o_data_valid;

  modport master (
    output i_data, i_valid,
    input  o_ready, o_data, o_value, o_data_valid
  );

  modport slave (
    input  i_data, i_valid,
    output o_ready, o_data, o_value, o_data_valid
  );
endinterface

// File: rtl/argmax_scan_unit.sv
// Argmax/argmin over a buffered score vector, LANES elements per cycle; result pulses S cycles after accept.
// o_ready is low for the whole scan, so upstream stalls; i_valid during a scan is ignored, nothing is queued.
module argmax_scan_unit #(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16,
  parameter int LANES       = 1,
  parameter bit SIGNED_CMP  = 1'b0,
  parameter bit FIND_MIN    = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  argmax_scan_unit_if.slave bus
);
  localparam int IDX_W = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  // Wide enough for ptr plus one lane step past the end of the vector.
  localparam int PTR_W = $clog2(NUM_INPUT + 2*LANES) + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                           state_q, state_d;
  logic [NUM_INPUT*INPUT_WIDTH-1:0] buf_q;
  logic [PTR_W-1:0]                 ptr_q;
  logic [INPUT_WIDTH-1:0]           best_val_q, best_val_d, res_val_q;
  logic [IDX_W-1:0]                 best_idx_q, best_idx_d, res_idx_q;
  logic                             res_vld_q;
  logic                             accept, scan_last;
  logic [PTR_W-1:0]                 cand_idx;
  logic [INPUT_WIDTH-1:0]           cand_val;

  function automatic logic beats(input logic [INPUT_WIDTH-1:0] a,
                                 input logic [INPUT_WIDTH-1:0] b);
    logic r;
    if (SIGNED_CMP) r = FIND_MIN ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
    else            r = FIND_MIN ? (a < b) : (a > b);
    return r;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_valid) state_d = SCAN;
      SCAN:    if (scan_last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready = (state_q == IDLE);
    accept      = bus.i_valid && (state_q == IDLE);
    scan_last   = (state_q == SCAN) && ((ptr_q + PTR_W'(LANES)) >= PTR_W'(NUM_INPUT));
  end

  // Lanes are visited in ascending index with a strict compare, so ties keep the lower index.
  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    cand_idx   = '0;
    cand_val   = '0;
    for (int l = 0; l < LANES; l++) begin
      cand_idx = ptr_q + PTR_W'(l);
      cand_val = '0;
      for (int e = 0; e < NUM_INPUT; e++) begin
        if (cand_idx == PTR_W'(e)) cand_val = buf_q[e*INPUT_WIDTH +: INPUT_WIDTH];
      end
      if ((cand_idx < PTR_W'(NUM_INPUT)) && beats(cand_val, best_val_d)) begin
        best_val_d = cand_val;
        best_idx_d = IDX_W'(cand_idx);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q      <= '0;
      ptr_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      res_val_q  <= '0;
      res_idx_q  <= '0;
      res_vld_q  <= 1'b0;
    end else begin
      res_vld_q <= scan_last;
      if (accept) begin
        buf_q      <= bus.i_data;
        best_val_q <= bus.i_data[INPUT_WIDTH-1:0];
        best_idx_q <= '0;
        ptr_q      <= PTR_W'(1);
      end else if (state_q == SCAN) begin
        best_val_q <= best_val_d;
        best_idx_q <= best_idx_d;
        ptr_q      <= ptr_q + PTR_W'(LANES);
      end
      // Result registers hold until the next scan completes.
      if (scan_last) begin
        res_val_q <= best_val_d;
        res_idx_q <= best_idx_d;
      end
    end
  end

  assign bus.o_data       = 32'(res_idx_q);
  assign bus.o_value      = res_val_q;
  assign bus.o_data_valid = res_vld_q;
endmodule

// File: tb/tb_argmax_scan_unit.sv
// Six parameterisations of the scanner checked against a queue of expected results (index, value, due cycle).
module tb_argmax_scan_unit;
  localparam int NI = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         vin  [NI];
  logic [159:0] din  [NI];
  logic         rdy  [NI];
  logic         vld  [NI];
  logic [31:0]  odat [NI];
  logic [15:0]  oval [NI];

  typedef struct packed {
    logic [31:0] idx;
    logic [15:0] val;
    logic [31:0] due;
  } exp_t;

  exp_t q [NI][$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // u0 max N10 L1, u1 signed N4 L2, u2 unsigned N4 L2, u3 min N10 L3, u4 N1, u5 N10 L10
  argmax_scan_unit_if #(.NUM_INPUT(10), .INPUT_WIDTH(16)) if0 ();
  argmax_scan_unit_if #(.NUM_INPUT(4),  .INPUT_WIDTH(16)) if1 ();
  argmax_scan_unit_if #(.NUM_INPUT(4),  .INPUT_WIDTH(16)) if2 ();
  argmax_scan_unit_if #(.NUM_INPUT(10), .INPUT_WIDTH(16)) if3 ();
  argmax_scan_unit_if #(.NUM_INPUT(1),  .INPUT_WIDTH(16)) if4 ();
  argmax_scan_unit_if #(.NUM_INPUT(10), .INPUT_WIDTH(16)) if5 ();

  argmax_scan_unit #(.NUM_INPUT(10), .INPUT_WIDTH(16), .LANES(1),  .SIGNED_CMP(1'b0), .FIND_MIN(1'b0))
    u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  argmax_scan_unit #(.NUM_INPUT(4),  .INPUT_WIDTH(16), .LANES(2),  .SIGNED_CMP(1'b1), .FIND_MIN(1'b0))
    u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  argmax_scan_unit #(.NUM_INPUT(4),  .INPUT_WIDTH(16), .LANES(2),  .SIGNED_CMP(1'b0), .FIND_MIN(1'b0))
    u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));
  argmax_scan_unit #(.NUM_INPUT(10), .INPUT_WIDTH(16), .LANES(3),  .SIGNED_CMP(1'b0), .FIND_MIN(1'b1))
    u3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));
  argmax_scan_unit #(.NUM_INPUT(1),  .INPUT_WIDTH(16), .LANES(1),  .SIGNED_CMP(1'b0), .FIND_MIN(1'b0))
    u4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));
  argmax_scan_unit #(.NUM_INPUT(10), .INPUT_WIDTH(16), .LANES(10), .SIGNED_CMP(1'b0), .FIND_MIN(1'b0))
    u5 (.i_clk(clk), .i_rst_n(rst_n), .bus(if5));

  assign if0.i_valid = vin[0]; assign if0.i_data = din[0];
  assign if1.i_valid = vin[1]; assign if1.i_data = din[1][63:0];
  assign if2.i_valid = vin[2]; assign if2.i_data = din[2][63:0];
  assign if3.i_valid = vin[3]; assign if3.i_data = din[3];
  assign if4.i_valid = vin[4]; assign if4.i_data = din[4][15:0];
  assign if5.i_valid = vin[5]; assign if5.i_data = din[5];

  assign rdy[0] = if0.o_ready; assign vld[0] = if0.o_data_valid; assign odat[0] = if0.o_data; assign oval[0] = if0.o_value;
  assign rdy[1] = if1.o_ready; assign vld[1] = if1.o_data_valid; assign odat[1] = if1.o_data; assign oval[1] = if1.o_value;
  assign rdy[2] = if2.o_ready; assign vld[2] = if2.o_data_valid; assign odat[2] = if2.o_data; assign oval[2] = if2.o_value;
  assign rdy[3] = if3.o_ready; assign vld[3] = if3.o_data_valid; assign odat[3] = if3.o_data; assign oval[3] = if3.o_value;
  assign rdy[4] = if4.o_ready; assign vld[4] = if4.o_data_valid; assign odat[4] = if4.o_data; assign oval[4] = if4.o_value;
  assign rdy[5] = if5.o_ready; assign vld[5] = if5.o_data_valid; assign odat[5] = if5.o_data; assign oval[5] = if5.o_value;

  function automatic int n_of(input int k);
    case (k)
      1, 2:    return 4;
      4:       return 1;
      default: return 10;
    endcase
  endfunction

  function automatic int l_of(input int k);
    case (k)
      1, 2:    return 2;
      3:       return 3;
      5:       return 10;
      default: return 1;
    endcase
  endfunction

  function automatic int lat(input int k);
    int s;
    s = (n_of(k) - 1 + l_of(k) - 1) / l_of(k);
    return (s < 1) ? 1 : s;
  endfunction

  // Reference: linear scan, strict compare keeps the first winner.
  function automatic int ref_idx(input logic [159:0] v, input int n, input bit sgn, input bit mn);
    int b;
    logic [15:0] x, y;
    logic better;
    b = 0;
    for (int i = 1; i < n; i++) begin
      x = v[i*16 +: 16];
      y = v[b*16 +: 16];
      if (sgn) better = mn ? ($signed(x) < $signed(y)) : ($signed(x) > $signed(y));
      else     better = mn ? (x < y) : (x > y);
      if (better) b = i;
    end
    return b;
  endfunction

  function automatic logic [159:0] rnd_vec();
    logic [159:0] v;
    for (int i = 0; i < 10; i++)
      v[i*16 +: 16] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (vld[k] !== 1'b0) begin
        checks++;
        assert (q[k].size() > 0) else begin
          errors++;
          $error("FAIL u%0d_stray_pulse got=%0h exp=0", k, vld[k]);
        end
        if (q[k].size() > 0) begin
          mon_e = q[k].pop_front();
          chk($sformatf("u%0d_idx", k), odat[k], mon_e.idx);
          chk($sformatf("u%0d_val", k), 32'(oval[k]), 32'(mon_e.val));
          chk($sformatf("u%0d_cycle", k), 32'(cyc), mon_e.due);
        end
      end
    end
  end

  task automatic send(input int k, input logic [159:0] v, input int eidx, input logic [15:0] eval,
                      input bit hold, output int acc);
    int w;
    int s;
    exp_t e;
    s = lat(k);
    din[k] = v;
    vin[k] = 1'b1;
    w = 0;
    while (rdy[k] !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("u%0d_ready_before_accept", k), 32'(rdy[k]), 32'd1);
    @(posedge clk);
    #1;
    acc   = cyc;
    e.idx = 32'(eidx);
    e.val = eval;
    e.due = 32'(cyc + s);
    q[k].push_back(e);
    for (int i = 0; i < s; i++) begin
      @(negedge clk);
      chk($sformatf("u%0d_busy", k), 32'(rdy[k]), 32'd0);
    end
    if (!hold) vin[k] = 1'b0;
  endtask

  task automatic send_model(input int k, input bit sgn, input bit mn);
    logic [159:0] v;
    int idx;
    int acc;
    v   = rnd_vec();
    idx = ref_idx(v, n_of(k), sgn, mn);
    send(k, v, idx, v[idx*16 +: 16], 1'b0, acc);
  endtask

  initial begin
    int acc_a, acc_b, acc;
    logic [159:0] v;
    for (int k = 0; k < NI; k++) begin
      vin[k] = 1'b0;
      din[k] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d_rst_ready", k), 32'(rdy[k]), 32'd1);
      chk($sformatf("u%0d_rst_valid", k), 32'(vld[k]), 32'd0);
    end
    chk("rst_data", odat[0], 32'd0);
    chk("rst_value", 32'(oval[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back with i_valid held: A (max at 8) then B (max at 0)
    v = {16'd9, 16'd100, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    send(0, v, 8, 16'd100, 1'b1, acc_a);
    v = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd50};
    send(0, v, 0, 16'd50, 1'b0, acc_b);
    chk("b2b_accept_gap", 32'(acc_b), 32'(acc_a + 10));

    // Unsigned max with a duplicated maximum
    v = {16'd6, 16'd4, 16'd0, 16'd2, 16'h7FFF, 16'd5, 16'h7FFF, 16'd1, 16'd9, 16'd3};
    send(0, v, 3, 16'h7FFF, 1'b0, acc);
    repeat (3) @(negedge clk);

    // Async reset four cycles into a scan
    v = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
    din[0] = v;
    vin[0] = 1'b1;
    chk("mid_rst_ready_before", 32'(rdy[0]), 32'd1);
    @(posedge clk);
    #1 vin[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", odat[0], 32'd0);
    chk("mid_rst_value", 32'(oval[0]), 32'd0);
    chk("mid_rst_valid", 32'(vld[0]), 32'd0);
    chk("mid_rst_ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    send_model(0, 1'b0, 1'b0);

    // Signed versus unsigned on the same vector
    v = 160'({16'h0000, 16'h0001, 16'hFFFF, 16'h8000});
    send(1, v, 2, 16'h0001, 1'b0, acc);
    send(2, v, 1, 16'hFFFF, 1'b0, acc);

    // Min mode with a tie at the minimum
    v = {16'd3, 16'd5, 16'd2, 16'd2, 16'd8, 16'd8, 16'd4, 16'd9, 16'd4, 16'd7};
    send(3, v, 6, 16'd2, 1'b0, acc);

    // Edge sizes
    v = 160'(16'h1234);
    send(4, v, 0, 16'h1234, 1'b0, acc);
    v = {10{16'h0055}};
    send(5, v, 0, 16'h0055, 1'b0, acc);

    for (int r = 0; r < 3; r++) begin
      send_model(0, 1'b0, 1'b0);
      send_model(1, 1'b1, 1'b0);
      send_model(3, 1'b0, 1'b1);
    end

    repeat (20) @(negedge clk);
    for (int k = 0; k < NI; k++)
      chk($sformatf("u%0d_pending_results", k), 32'(q[k].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
